// File: rtl/mem_pkg.sv
// Shared constants and types for the memory stage.
// Opcodes, FSM state encoding and the memory-timeout exception code.
package mem_pkg;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    localparam logic [2:0] EXC_NONE        = 3'b000;
    localparam logic [2:0] EXC_MEM_TIMEOUT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on data memory.
// tc_o fires in the LIMIT-th enabled cycle after a clear.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == TC_VAL);

    // Clear wins over counting; the count parks at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues lw/sw to data memory and stalls the pipe until ack.
// Optional ack timeout is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] ir_in,
    input  logic [1:0]  in_type,
    input  logic [2:0]  in_exception,
    input  logic [31:0] inALU,
    input  logic [31:0] inB,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [11:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] outMEM,
    output logic [2:0]  out_exception,
    output logic        block
);

    mem_state_e  state_q, state_d;
    logic [31:0] out_mem_q, out_mem_d;
    logic        exc_to_q, exc_to_d;
    logic [11:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;

    logic [4:0]  opcode;
    logic        start;
    logic        in_wait;
    logic        timeout_hit;

    assign opcode  = ir_in[31:27];
    assign in_wait = (state_q == ST_WAIT);
    assign start   = (state_q == ST_IDLE) && is_mem_op(opcode)
                  && (in_exception == EXC_NONE) && !flush;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (in_wait),
        .clr_i (!in_wait || flush),
        .tc_o  (timeout_hit)
    );

    logic unused_bits;
    assign unused_bits = &{1'b0, ir_in[26:0], in_type, inALU[31:12]};
`else
    assign timeout_hit = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, ir_in[26:0], in_type, inALU[31:12],
                           32'(TIMEOUT_CYCLES)};
`endif

    // Next state: flush beats ack, ack beats timeout.
    always_comb begin
        state_d   = state_q;
        out_mem_d = out_mem_q;
        exc_to_d  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start)
                        state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state_d = ST_DONE;
                        if (!we_q)
                            out_mem_d = dmem_rdata;
                    end else if (timeout_hit) begin
                        state_d   = ST_DONE;
                        out_mem_d = '0;
                        exc_to_d  = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, load data and timeout flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            out_mem_q <= '0;
            exc_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_mem_q <= out_mem_d;
            exc_to_q  <= exc_to_d;
        end
    end

    // Freeze the request fields on issue so they cannot move during WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (start) begin
            addr_q  <= inALU[11:0];
            we_q    <= (opcode == OP_SW);
            wdata_q <= inB;
        end
    end

    assign dmem_req   = in_wait && !reset;
    assign block      = !reset && (start || in_wait);
    assign dmem_we    = in_wait ? we_q    : (opcode == OP_SW);
    assign dmem_addr  = in_wait ? addr_q  : inALU[11:0];
    assign dmem_wdata = in_wait ? wdata_q : inB;
    assign outMEM     = out_mem_q;

    // Timeout code replaces the upstream code only in its DONE cycle.
    always_comb begin
        out_exception = in_exception;
        if (reset)
            out_exception = EXC_NONE;
        else if ((state_q == ST_DONE) && exc_to_q)
            out_exception = EXC_MEM_TIMEOUT;
    end

endmodule
